// File: rtl/lc3b_pipe_pkg.sv
// lc3b_pipe_pkg: shared word width, reset PC and PCMUX encodings for the LC-3b pipeline
package lc3b_pipe_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t RESET_PC_DEFAULT = 16'h3000;
    typedef enum logic [1:0] {
        PCMUX_NEXT   = 2'd0,
        PCMUX_TARGET = 2'd1,
        PCMUX_TRAP   = 2'd2,
        PCMUX_RSVD   = 2'd3
    } pcmux_e;
endpackage

// File: rtl/fetch_pc_mux.sv
// fetch_pc_mux: next-PC select between PC+2, MEM target and trap vector (bit 0 cleared on redirects)
// ports: pc_plus2/target_pc/trap_pc candidate PCs in, pcmux select in, next_pc out
module fetch_pc_mux
    import lc3b_pipe_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus2,
    input  logic [WORD_W-1:0] target_pc,
    input  logic [WORD_W-1:0] trap_pc,
    input  logic [1:0]        pcmux,
    output logic [WORD_W-1:0] next_pc
);
    always_comb begin
        next_pc = pcmux == PCMUX_TARGET ? {target_pc[WORD_W-1:1], 1'b0}
                : pcmux == PCMUX_TRAP   ? {trap_pc[WORD_W-1:1], 1'b0}
                :                         pc_plus2;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b fetch stage holding the PC and loading the DE latch, with stall and redirect handling
// ports: clk/reset; icache_addr/icache_data/icache_r cache side; dep_stall, mem_stall, v_*_br_stall stalls;
//        mem_pcmux/target_pc/trap_pc redirect from MEM; de_npc/de_ir/de_v DE latch; fetch_count valid loads
module fetch_stage
    import lc3b_pipe_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] icache_addr,
    input  logic [WORD_W-1:0] icache_data,
    input  logic              icache_r,
    input  logic              dep_stall,
    input  logic              mem_stall,
    input  logic              v_de_br_stall,
    input  logic              v_agex_br_stall,
    input  logic              v_mem_br_stall,
    input  logic [1:0]        mem_pcmux,
    input  logic [WORD_W-1:0] target_pc,
    input  logic [WORD_W-1:0] trap_pc,
    output logic [WORD_W-1:0] de_npc,
    output logic [WORD_W-1:0] de_ir,
    output logic              de_v,
    output logic [WORD_W-1:0] fetch_count
);
    logic [WORD_W-1:0] pc_q, pc_d, pc_plus2, next_pc;
    logic [WORD_W-1:0] de_npc_q, de_npc_d, de_ir_q, de_ir_d, count_q, count_d;
    logic              de_v_q, de_v_d;
    logic              br_stall, redirect, ld_de, ld_pc, new_v;

    fetch_pc_mux u_pc_mux (
        .pc_plus2  (pc_plus2),
        .target_pc (target_pc),
        .trap_pc   (trap_pc),
        .pcmux     (redirect ? mem_pcmux : 2'(PCMUX_NEXT)),
        .next_pc   (next_pc)
    );

    always_comb begin
        br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
        // a stalled MEM stage must not redirect; the transfer is retried once it drains
        redirect = (mem_pcmux == PCMUX_TARGET || mem_pcmux == PCMUX_TRAP) && !mem_stall;
        ld_de    = !dep_stall && !mem_stall;
        ld_pc    = redirect || (icache_r && ld_de && !br_stall);
        pc_plus2 = pc_q + 16'd2;
        new_v    = icache_r && !br_stall;
        pc_d     = ld_pc ? next_pc : pc_q;
        de_ir_d  = ld_de ? icache_data : de_ir_q;
        de_npc_d = ld_de ? pc_plus2 : de_npc_q;
        de_v_d   = ld_de ? new_v : de_v_q;
        count_d  = count_q + {15'd0, ld_de && new_v};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            de_ir_q  <= '0;
            de_npc_q <= '0;
            de_v_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            de_ir_q  <= de_ir_d;
            de_npc_q <= de_npc_d;
            de_v_q   <= de_v_d;
            count_q  <= count_d;
        end
    end

    assign icache_addr = pc_q;
    assign de_npc      = de_npc_q;
    assign de_ir       = de_ir_q;
    assign de_v        = de_v_q;
    assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, icache_r, dep_stall, mem_stall;
    logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
    logic [1:0]  mem_pcmux;
    logic [15:0] target_pc, trap_pc, icache_addr, icache_data, de_npc, de_ir, fetch_count;
    logic        de_v;
    logic        use_force;
    logic [15:0] force_data;
    int          n_tests = 0;
    int          n_fail = 0;

    // instruction memory image: word at address a is a ^ 16'h5A00 unless overridden
    assign icache_data = use_force ? force_data : (icache_addr ^ 16'h5A00);

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .icache_addr(icache_addr), .icache_data(icache_data),
        .icache_r(icache_r), .dep_stall(dep_stall), .mem_stall(mem_stall),
        .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
        .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux), .target_pc(target_pc),
        .trap_pc(trap_pc), .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v), .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; icache_r = 1; dep_stall = 0; mem_stall = 0;
        v_de_br_stall = 0; v_agex_br_stall = 0; v_mem_br_stall = 0;
        mem_pcmux = 2'd0; target_pc = 16'h0; trap_pc = 16'h0; use_force = 0; force_data = 16'h0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; mem_pcmux = 2'd2; trap_pc = 16'h1234; v_mem_br_stall = 1;
        tick();
        n_tests++; if (icache_addr !== 16'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want 3000", icache_addr); end
        n_tests++; if (de_v !== 1'b0) begin n_fail++; $display("FAIL reset_de_v: got %b want 0", de_v); end
        n_tests++; if (de_ir !== 16'h0) begin n_fail++; $display("FAIL reset_de_ir: got %h want 0000", de_ir); end
        n_tests++; if (de_npc !== 16'h0) begin n_fail++; $display("FAIL reset_de_npc: got %h want 0000", de_npc); end
        n_tests++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0000", fetch_count); end
        idle();
    endtask

    task automatic test_hits();
        logic [15:0] pc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pc = 16'h3000 + 16'(2 * i);
            tick();
            n_tests++; if (de_npc !== pc + 16'd2) begin n_fail++; $display("FAIL hit_npc%0d: got %h want %h", i, de_npc, pc + 16'd2); end
            n_tests++; if (de_ir !== (pc ^ 16'h5A00)) begin n_fail++; $display("FAIL hit_ir%0d: got %h want %h", i, de_ir, pc ^ 16'h5A00); end
            n_tests++; if (de_v !== 1'b1) begin n_fail++; $display("FAIL hit_v%0d: got %b want 1", i, de_v); end
        end
        n_tests++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL hit_count: got %0d want 4", fetch_count); end
        n_tests++; if (icache_addr !== 16'h3008) begin n_fail++; $display("FAIL hit_pc: got %h want 3008", icache_addr); end
    endtask

    task automatic test_miss();
        do_reset();
        tick(); tick();
        icache_r = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (icache_addr !== 16'h3004) begin n_fail++; $display("FAIL miss_pc%0d: got %h want 3004", i, icache_addr); end
            n_tests++; if (de_v !== 1'b0) begin n_fail++; $display("FAIL miss_v%0d: got %b want 0", i, de_v); end
            n_tests++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL miss_count%0d: got %0d want 2", i, fetch_count); end
        end
        icache_r = 1;
        tick();
        n_tests++; if (de_npc !== 16'h3006 || de_v !== 1'b1) begin n_fail++; $display("FAIL miss_resume: got npc %h v %b want 3006 1", de_npc, de_v); end
        n_tests++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL miss_resume_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_dep_stall();
        use_force = 1; force_data = 16'h1234;
        tick();
        n_tests++; if (de_ir !== 16'h1234 || de_npc !== 16'h3008) begin n_fail++; $display("FAIL dep_load: got ir %h npc %h want 1234 3008", de_ir, de_npc); end
        use_force = 0; dep_stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (de_ir !== 16'h1234) begin n_fail++; $display("FAIL dep_ir%0d: got %h want 1234", i, de_ir); end
            n_tests++; if (de_npc !== 16'h3008) begin n_fail++; $display("FAIL dep_npc%0d: got %h want 3008", i, de_npc); end
            n_tests++; if (icache_addr !== 16'h3008) begin n_fail++; $display("FAIL dep_pc%0d: got %h want 3008", i, icache_addr); end
            n_tests++; if (de_v !== 1'b1 || fetch_count !== 16'd4) begin n_fail++; $display("FAIL dep_hold%0d: got v %b cnt %0d want 1 4", i, de_v, fetch_count); end
        end
        dep_stall = 0;
        tick();
        n_tests++; if (de_ir !== (16'h3008 ^ 16'h5A00) || de_npc !== 16'h300A) begin n_fail++; $display("FAIL dep_release: got ir %h npc %h want %h 300a", de_ir, de_npc, 16'h3008 ^ 16'h5A00); end
        n_tests++; if (icache_addr !== 16'h300A || fetch_count !== 16'd5) begin n_fail++; $display("FAIL dep_release_pc: got pc %h cnt %0d want 300a 5", icache_addr, fetch_count); end
    endtask

    task automatic test_branch();
        v_de_br_stall = 1;
        tick();
        n_tests++; if (de_v !== 1'b0 || icache_addr !== 16'h300A) begin n_fail++; $display("FAIL br_de: got v %b pc %h want 0 300a", de_v, icache_addr); end
        v_de_br_stall = 0; v_agex_br_stall = 1;
        tick();
        n_tests++; if (de_v !== 1'b0 || icache_addr !== 16'h300A) begin n_fail++; $display("FAIL br_agex: got v %b pc %h want 0 300a", de_v, icache_addr); end
        v_agex_br_stall = 0; v_mem_br_stall = 1; mem_pcmux = 2'd1; target_pc = 16'h4001; icache_r = 0;
        tick();
        n_tests++; if (de_v !== 1'b0) begin n_fail++; $display("FAIL br_mem_v: got %b want 0", de_v); end
        n_tests++; if (icache_addr !== 16'h4000) begin n_fail++; $display("FAIL br_target_pc: got %h want 4000", icache_addr); end
        idle();
        tick();
        n_tests++; if (de_npc !== 16'h4002 || de_v !== 1'b1) begin n_fail++; $display("FAIL br_first: got npc %h v %b want 4002 1", de_npc, de_v); end
        n_tests++; if (de_ir !== (16'h4000 ^ 16'h5A00) || fetch_count !== 16'd6) begin n_fail++; $display("FAIL br_first_ir: got ir %h cnt %0d want %h 6", de_ir, fetch_count, 16'h4000 ^ 16'h5A00); end
    endtask

    task automatic test_mem_stall_trap();
        mem_pcmux = 2'd2; trap_pc = 16'h0200; v_mem_br_stall = 1; mem_stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (icache_addr !== 16'h4002) begin n_fail++; $display("FAIL ms_pc%0d: got %h want 4002", i, icache_addr); end
            n_tests++; if (de_v !== 1'b1 || de_npc !== 16'h4002) begin n_fail++; $display("FAIL ms_de%0d: got v %b npc %h want 1 4002", i, de_v, de_npc); end
        end
        mem_stall = 0;
        tick();
        n_tests++; if (icache_addr !== 16'h0200) begin n_fail++; $display("FAIL trap_pc: got %h want 0200", icache_addr); end
        n_tests++; if (de_v !== 1'b0 || fetch_count !== 16'd6) begin n_fail++; $display("FAIL trap_bubble: got v %b cnt %0d want 0 6", de_v, fetch_count); end
        idle();
        tick();
        n_tests++; if (de_npc !== 16'h0202 || de_v !== 1'b1) begin n_fail++; $display("FAIL trap_first: got npc %h v %b want 0202 1", de_npc, de_v); end
    endtask

    task automatic test_wrap();
        v_mem_br_stall = 1; mem_pcmux = 2'd1; target_pc = 16'hFFFF;
        tick();
        n_tests++; if (icache_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_setup: got %h want fffe", icache_addr); end
        idle();
        tick();
        n_tests++; if (de_npc !== 16'h0000 || de_ir !== (16'hFFFE ^ 16'h5A00)) begin n_fail++; $display("FAIL wrap_npc: got npc %h ir %h want 0000 %h", de_npc, de_ir, 16'hFFFE ^ 16'h5A00); end
        n_tests++; if (icache_addr !== 16'h0000 || fetch_count !== 16'd8) begin n_fail++; $display("FAIL wrap_pc: got pc %h cnt %0d want 0000 8", icache_addr, fetch_count); end
        mem_pcmux = 2'd3; target_pc = 16'h7000; trap_pc = 16'h7100;
        tick();
        n_tests++; if (icache_addr !== 16'h0002 || de_npc !== 16'h0002) begin n_fail++; $display("FAIL pcmux_rsvd: got pc %h npc %h want 0002 0002", icache_addr, de_npc); end
        idle();
    endtask

    task automatic test_reset_mid_redirect();
        v_mem_br_stall = 1; mem_pcmux = 2'd1; target_pc = 16'h5000; reset = 1;
        tick();
        n_tests++; if (icache_addr !== 16'h3000) begin n_fail++; $display("FAIL rst_redir_pc: got %h want 3000", icache_addr); end
        n_tests++; if (de_v !== 1'b0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL rst_redir_de: got v %b cnt %0d want 0 0", de_v, fetch_count); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_hits();
        test_miss();
        test_dep_stall();
        test_branch();
        test_mem_stall_trap();
        test_wrap();
        test_reset_mid_redirect();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the LC-3b five-stage pipeline. Holds the PC and issues instruction-cache requests. Loads the DE pipeline latch (`de_npc`, `de_ir`, `de_v`) that feeds the decode stage. Honours decode dependency stalls, memory stalls and branch-shadow stalls, and redirects the PC when the MEM stage resolves a control transfer.

## Interface
- `RESET_PC`, 16'h3000, PC value after reset.
- `clk` input 1: pipeline clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `icache_addr` output 16: current PC, presented to the instruction cache.
- `icache_data` input 16: instruction word at `icache_addr`, valid when `icache_r`=1.
- `icache_r` input 1: cache hit/ready this cycle.
- `dep_stall` input 1: decode has an operand or CC dependency; hold DE.
- `mem_stall` input 1: MEM stage stalled; hold DE and PC.
- `v_de_br_stall`, `v_agex_br_stall`, `v_mem_br_stall` input 1 each: a valid control instruction is in DE/AGEX/MEM.
- `mem_pcmux` input 2: 0 = PC+2, 1 = `target_pc`, 2 = `trap_pc`, 3 = reserved (treated as 0).
- `target_pc` input 16: branch/JMP/JSR target from MEM.
- `trap_pc` input 16: trap vector contents from MEM.
- `de_npc` output 16: PC+2 of the latched instruction.
- `de_ir` output 16: latched instruction.
- `de_v` output 1: DE latch holds a valid instruction.
- `fetch_count` output 16: count of valid instructions loaded into DE; wraps.

## Operation
- `br_stall` = OR of the three `v_*_br_stall` signals.
- `redirect` = (`mem_pcmux`==1 or 2) and not `mem_stall`.
- `ld_de` = not `dep_stall` and not `mem_stall`.
- `ld_pc` = `redirect` or (`icache_r` and `ld_de` and not `br_stall`).
- Next PC:
  - If `redirect`: `target_pc` (pcmux 1) or `trap_pc` (pcmux 2), with bit 0 forced to 0.
  - Otherwise: PC+2, modulo 2^16; 16'hFFFE+2 = 16'h0000.
- On `ld_de`:
  - `de_ir` <= `icache_data`, `de_npc` <= PC+2.
  - `de_v` <= `icache_r` and not `br_stall`.
- When `ld_de`=0, all DE outputs hold their values.
- A redirect cycle always loads a bubble (`de_v`=0), because `v_mem_br_stall` is asserted in that cycle.
- `fetch_count` increments on each cycle where `ld_de`=1 and the new `de_v`=1.
- Redirect takes priority over every stall except `mem_stall`.
- `icache_addr` = PC at all times, combinational from the PC register.
- There is no internal FSM beyond the PC/DE registers. Miss handling is implicit: while `icache_r`=0 and DE is loadable, a bubble enters DE and the PC holds.

## Timing
- Reset (when `reset`=1 at an edge):
  - PC=`RESET_PC`, `de_ir`=16'h0000, `de_npc`=16'h0000, `de_v`=0, `fetch_count`=0.
  - Reset overrides all other inputs, including a mid-redirect.
- Fetch-to-DE latency is 1 cycle: the word at PC in cycle N appears on `de_ir` after edge N.
- With a hit and no stalls, one instruction per cycle; PC advances by 2 every cycle.
- Redirect: the PC holds the new target after edge N, and the first target instruction is in DE after edge N+1.
- `dep_stall` with `icache_r`=1: PC and DE hold, the fetched word is not lost, and it is re-read next cycle.
- `mem_stall` and `redirect`-qualifying pcmux together: no redirect. The PC holds until `mem_stall` drops.
- `br_stall` with `icache_r`=1 and `ld_de`: PC holds and a bubble enters DE.
- Simultaneous `icache_r`=0 and `redirect`: redirect wins; PC loads the target.

## Structure
- Shared package `lc3b_pipe_pkg` holds:
  - PCMUX encodings `PCMUX_NEXT`/`PCMUX_TARGET`/`PCMUX_TRAP`;
  - default `RESET_PC`;
  - 16-bit word width constant.
- One natural sub-module, `fetch_pc_mux`: combinational next-PC select (PC+2 / target / trap, with bit-0 clear).
- PC, DE latch and counter registers live in `fetch_stage` itself.

## Test plan
- Reset, then 4 hit cycles from 16'h3000: `de_npc` = 3002, 3004, 3006, 3008; `de_v`=1; `fetch_count`=4.
- `icache_r`=0 for 3 cycles at PC 16'h3004: PC holds at 3004, `de_v`=0 for 3 cycles, and `fetch_count` does not increment.
- `dep_stall` for 2 cycles with `de_ir`=16'h1234 latched: `de_ir`, `de_npc` and PC hold. On release, the next word loads.
- `v_de_br_stall` then `v_agex_br_stall` then `mem_pcmux`=1 with `target_pc`=16'h4001 → 3 bubbles, then PC=16'h4000, then `de_npc`=16'h4002 with `de_v`=1.
- `mem_pcmux`=2, `trap_pc`=16'h0200, `mem_stall`=1 for 2 cycles: PC holds. In the cycle after `mem_stall` drops, PC=16'h0200.
- PC=16'hFFFE with a hit → `de_npc`=16'h0000 and PC wraps to 16'h0000.
- Also: assert `reset` mid-redirect → PC=16'h3000 and `de_v`=0 next cycle.
